// File: rtl/reg_file.sv
// Architectural integer register file: two combinational read ports, one write port,
// x0 hardwired to zero, and a post-reset sequencer that zeroes the array one entry per clock.
module reg_file #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(NREGS)-1:0]   a1,
  input  logic [$clog2(NREGS)-1:0]   a2,
  output logic [WIDTH-1:0]           rd1,
  output logic [WIDTH-1:0]           rd2,
  input  logic                       we3,
  input  logic [$clog2(NREGS)-1:0]   a3,
  input  logic [WIDTH-1:0]           wd3,
  output logic                       busy
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  typedef enum logic {StClear, StRun} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [WIDTH-1:0]  mem_wd;
  logic [WIDTH-1:0]  mem_q [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StClear;
      cnt_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entry 0 is never stored to; reads of address 0 are forced to zero instead.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_wa  = a3;
    mem_wd  = wd3;
    unique case (state_q)
      StClear: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        if (cnt_q == LastIdx) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      StRun: begin
        mem_we = we3 && (a3 != '0);
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  // No reset on the array so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign busy = (state_q == StClear);

  always_comb begin
    rd1 = '0;
    if (state_q == StRun && a1 != '0) begin
      if (BYPASS != 0 && we3 && a3 == a1) begin
        rd1 = wd3;
      end else begin
        rd1 = mem_q[a1];
      end
    end
  end

  always_comb begin
    rd2 = '0;
    if (state_q == StRun && a2 != '0) begin
      if (BYPASS != 0 && we3 && a3 == a2) begin
        rd2 = wd3;
      end else begin
        rd2 = mem_q[a2];
      end
    end
  end

endmodule
